// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM encoding and chunk-count helpers.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned calc_nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // A single chunk still needs a 1-bit index register.
  function automatic int unsigned calc_idx_w(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_rca.sv
// CHUNK-bit combinational ripple-carry adder; also exposes the carry into its MSB.
module rca_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Chunk-serial adder/subtractor: processes CHUNK bits per clock through one shared RCA.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NChunk = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IdxW   = calc_idx_w(NChunk);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
  logic             chunk_cout, chunk_cmsb;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NChunk; i++) begin
      if (k_q == IdxW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  rca_chunk #(
    .CHUNK (CHUNK)
  ) u_rca (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .cmsb (chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Subtract is a + ~b + 1, so fold the inversion and forced carry in here.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NChunk; i++) begin
          if (k_q == IdxW'(i)) acc_d[i*CHUNK +: CHUNK] = chunk_sum;
        end
        carry_d = chunk_cout;
        if (k_q == LastIdx) begin
          k_d     = '0;
          sum_d   = acc_d;
          cout_d  = chunk_cout;
          ovf_d   = chunk_cout ^ chunk_cmsb;
          state_d = StDone;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 16/4 instance plus a degenerate 8/8 instance.
module tb_seq_chunk_adder;

  localparam int unsigned NC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start16 = 1'b0, start8 = 1'b0;
  logic        cin = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;

  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk (clk), .rst (rst), .start (start16), .a (a), .b (b), .cin (cin), .sub (sub),
    .busy (busy16), .done (done16), .sum (sum16), .cout (cout16), .ovf (ovf16)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk (clk), .rst (rst), .start (start8), .a (a[7:0]), .b (b[7:0]), .cin (cin), .sub (sub),
    .busy (busy8), .done (done8), .sum (sum8), .cout (cout8), .ovf (ovf8)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int unsigned ncomp = 0;
  int unsigned nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned w, input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic s);
    exp_t        e;
    logic [63:0] mask, yy, tot, lo;
    logic        cc;
    mask  = (64'd1 << w) - 64'd1;
    yy    = s ? (~{32'd0, y}) & mask : {32'd0, y} & mask;
    cc    = s ? 1'b1 : c;
    tot   = ({32'd0, x} & mask) + yy + {63'd0, cc};
    lo    = ({32'd0, x} & (mask >> 1)) + (yy & (mask >> 1)) + {63'd0, cc};
    e.sum  = 32'(tot & mask);
    e.cout = tot[w];
    e.ovf  = lo[w-1] ^ tot[w];
    return e;
  endfunction

  function automatic logic [31:0] cur_sum(input bit d8);
    return d8 ? {24'd0, sum8} : {16'd0, sum16};
  endfunction

  // One operation: push the model result at start, pop and compare when done appears.
  task automatic run_op(input bit d8, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts, input bit poke);
    exp_t        e;
    logic [31:0] prev_sum;
    int unsigned edges = 0, busyc = 0, inter = 0, both = 0, extra = 0;
    int unsigned lat;
    bit          seen = 1'b0;
    lat = d8 ? 2 : NC + 1;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts;
    if (d8) start8 = 1'b1; else start16 = 1'b1;
    sb.push_back(model(d8 ? 8 : 16, {16'd0, ta}, {16'd0, tb_}, tc, ts));
    prev_sum = cur_sum(d8);
    @(negedge clk);
    edges = 1;
    start8 = 1'b0; start16 = 1'b0;
    // Scramble inputs to prove they were captured on the start edge.
    a = ~ta; b = ~tb_; cin = ~tc; sub = ~ts;
    if (poke) begin start16 = 1'b1; a = 16'h0001; b = 16'h0001; end
    while (edges <= lat + 3 && !seen) begin
      if (d8 ? done8 : done16) begin
        seen = 1'b1;
      end else begin
        if (d8 ? busy8 : busy16) busyc++;
        if (cur_sum(d8) !== prev_sum) inter++;
        if (poke && edges == 3) start16 = 1'b0;
        @(negedge clk);
        edges++;
      end
    end
    check("latency", seen ? edges : 0, lat);
    e = sb.pop_front();
    check("sum", cur_sum(d8), e.sum);
    check("cout", {31'd0, d8 ? cout8 : cout16}, {31'd0, e.cout});
    check("ovf", {31'd0, d8 ? ovf8 : ovf16}, {31'd0, e.ovf});
    if (d8 ? busy8 : busy16) both++;
    check("busy_and_done", both, 0);
    check("busy_cycles", busyc, lat - 1);
    check("no_intermediate_sum", inter, 0);
    @(negedge clk);
    check("done_single_pulse", {31'd0, d8 ? done8 : done16}, 32'd0);
    check("sum_hold", cur_sum(d8), e.sum);
    if (poke) begin
      repeat (3) begin
        if (busy16 || done16) extra++;
        @(negedge clk);
      end
      check("no_queued_start", extra, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {30'd0, busy16, busy8}, 32'd0);
    check("rst_done", {30'd0, done16, done8}, 32'd0);
    check("rst_sum16", {16'd0, sum16}, 32'd0);
    check("rst_sum8", {24'd0, sum8}, 32'd0);
    check("rst_flags", {28'd0, cout16, ovf16, cout8, ovf8}, 32'd0);
    rst = 1'b0;

    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("wrap_sum", {16'd0, sum16}, 32'h0000);
    check("wrap_cout", {31'd0, cout16}, 32'd1);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("sovf_flag", {31'd0, ovf16}, 32'd1);
    run_op(1'b0, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    check("borrow_sum", {16'd0, sum16}, 32'hFFFE);
    run_op(1'b0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    check("subovf_sum", {16'd0, sum16}, 32'h7FFF);

    // Abort an operation with reset two edges after start.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    check("abort_no_done_1", {31'd0, done16}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy16}, 32'd0);
    check("abort_done", {31'd0, done16}, 32'd0);
    check("abort_sum", {16'd0, sum16}, 32'd0);
    rst = 1'b0;
    run_op(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    check("post_reset_sum", {16'd0, sum16}, 32'h2345);

    run_op(1'b0, 16'h00F0, 16'h000F, 1'b1, 1'b0, 1'b1);
    check("ignored_start_sum", {16'd0, sum16}, 32'h0100);

    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    run_op(1'b1, 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("deg_sum", {24'd0, sum8}, 32'h01);
    check("deg_cout", {31'd0, cout8}, 32'd1);
    run_op(1'b1, 16'h0080, 16'h0001, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per clock; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK = WIDTH SHALL be legal.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 a  input  WIDTH  first operand; sampled on the accepted start edge.
REQ-007 b  input  WIDTH  second operand; sampled on the accepted start edge.
REQ-008 cin  input  1  carry-in for add mode; sampled on the accepted start edge.
REQ-009 sub  input  1  mode: 0 = a+b+cin, 1 = a-b (a + ~b + 1, cin ignored); sampled on the accepted start edge.
REQ-010 busy  output  1  high while the operation is in progress (RUN state).
REQ-011 done  output  1  single-cycle pulse when the result is valid.
REQ-012 sum  output  WIDTH  result; registered.
REQ-013 cout  output  1  carry out of the MSB (in sub mode, 1 means no borrow).
REQ-014 ovf  output  1  two's-complement signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE with start=1, the block SHALL capture the operands, set the chunk index k=0, and enter RUN.
  - Captured b: b in add mode, ~b in sub mode.
  - Captured carry: cin in add mode, 1 in sub mode.
REQ-017 Each RUN cycle SHALL add captured chunk k of both operands plus the running carry, store CHUNK result bits, update the running carry and increment k.
REQ-018 After the edge that processes chunk NCHUNK-1 (NCHUNK = WIDTH/CHUNK), the FSM SHALL enter DONE.
  - On the same edge, sum, cout and ovf SHALL update.
REQ-019 done SHALL be 1 for exactly the one cycle spent in DONE; the FSM SHALL then return to IDLE unconditionally.
REQ-020 Latency: done SHALL assert exactly NCHUNK+1 rising edges after the accepted start edge.
  - Example: WIDTH=16, CHUNK=4 gives 5 edges.
REQ-021 busy SHALL be 1 exactly in RUN, and busy and done SHALL never be high together.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing.
  - Changes to a, b, cin or sub after capture SHALL not affect the result.
REQ-023 sum, cout and ovf SHALL hold their last values until the next DONE.
  - Intermediate chunk results SHALL never be visible on sum.
REQ-024 ovf SHALL use the carry into bit WIDTH-1, derived from the final chunk.
REQ-025 Wrap-around: results SHALL be modulo 2^WIDTH, with no saturation.

Reset
REQ-026 When rst=1 on a rising edge, the block SHALL enter IDLE and set busy=0, done=0, sum=0, cout=0, ovf=0, k=0.
REQ-027 Reset SHALL override start and any in-progress RUN or DONE; an aborted operation SHALL produce no done pulse.
REQ-028 A start presented in the cycle after rst deasserts SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE, RUN, DONE) and the NCHUNK derivation; chunk-index width SHALL be derived from it, with a minimum of 1 bit.
REQ-030 One combinational sub-module, rca_chunk (CHUNK-bit ripple-carry adder), SHALL be instantiated once.
  - Outputs: CHUNK-bit sum, carry out, and carry into its MSB.
  - All chunks SHALL be processed through this single instance.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0; done 5 edges after start; busy high for 4 cycles.
REQ-032 Signed overflow: a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-033 Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0; subtract overflow: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-034 Reset mid-operation: start with a=0x1234, b=0x1111, then rst=1 two edges later -> busy=0, done never pulses, sum=0; a new start on the next cycle yields 0x2345 after 5 edges.
REQ-035 Ignored start: start re-asserted with a=0x0001, b=0x0001 during RUN of a=0x00F0, b=0x000F, cin=1 -> single done pulse, sum=0x0100, no second operation begins.
REQ-036 Degenerate width: WIDTH=CHUNK=8: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, done 2 edges after start.
